// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and
// register-specifier defaults.
package ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_MEM_WAIT = 2'd3
  } ctrl_state_t;

  localparam int REG_ADDR_W_DEF = 5;

  // Register 0 is hard-wired to zero, so a load targeting it never creates a hazard.
  localparam logic [REG_ADDR_W_DEF-1:0] ZERO_REG = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection between the EX load and the ID
// instruction's source operands.
module load_use_detect
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  output logic                  lu
);

  logic rd_nonzero;
  logic rs_match;
  logic rt_match;

  assign rd_nonzero = (ex_rd != REG_ADDR_W'(ZERO_REG));
  assign rs_match   = (ex_rd == id_rs);
  assign rt_match   = id_uses_rt && (ex_rd == id_rt);
  assign lu         = ex_mem_read && rd_nonzero && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the PC and IF/ID stage: load-use stalls, taken-branch
// flushes, data-memory freezes, plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_write_en,
  output logic                  if_id_write_en,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic [CNT_W-1:0]      stall_count,
  output logic [1:0]            ctrl_state
);

  localparam logic [3:0]       FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  ctrl_state_t      state_reg, state_next;
  logic [3:0]       fcnt_reg, fcnt_next;
  logic [CNT_W-1:0] stall_count_reg;
  logic             lu;
  logic             pc_we, if_id_we, flush, bubble;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .lu          (lu)
  );

  always_comb begin
    pc_we      = 1'b1;
    if_id_we   = 1'b1;
    flush      = 1'b0;
    bubble     = 1'b0;
    state_next = state_reg;
    fcnt_next  = fcnt_reg;
    case (state_reg)
      ST_FLUSH: begin
        if (mem_busy) begin
          pc_we    = 1'b0;
          if_id_we = 1'b0;
        end else begin
          flush     = 1'b1;
          bubble    = 1'b1;
          fcnt_next = fcnt_reg - 4'd1;
          if (fcnt_reg == 4'd1) state_next = ST_RUN;
        end
      end
      default: begin
        // RUN, LU_STALL and a released MEM_WAIT share one decision path; only
        // LU_STALL masks lu so the same load cannot stall twice.
        if (mem_busy) begin
          pc_we      = 1'b0;
          if_id_we   = 1'b0;
          state_next = ST_MEM_WAIT;
        end else if (branch_taken) begin
          flush  = 1'b1;
          bubble = 1'b1;
          if (FLUSH_CYCLES == 1) begin
            state_next = ST_RUN;
          end else begin
            state_next = ST_FLUSH;
            fcnt_next  = FLUSH_INIT;
          end
        end else if (lu && (state_reg != ST_LU_STALL)) begin
          pc_we      = 1'b0;
          if_id_we   = 1'b0;
          bubble     = 1'b1;
          state_next = ST_LU_STALL;
        end else begin
          state_next = ST_RUN;
        end
      end
    endcase
  end

  assign pc_write_en    = Reset && pc_we;
  assign if_id_write_en = Reset && if_id_we;
  assign if_id_flush    = Reset && flush;
  assign id_ex_bubble   = Reset && bubble;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_reg       <= ST_RUN;
      fcnt_reg        <= 4'd0;
      stall_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      fcnt_reg  <= fcnt_next;
      if (!pc_we && (stall_count_reg != CNT_MAX))
        stall_count_reg <= stall_count_reg + CNT_W'(1);
    end
  end

  assign stall_count = stall_count_reg;
  assign ctrl_state  = state_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: a FLUSH_CYCLES=3/CNT_W=4 controller and a default-parameter
// controller share stimulus; each scenario task checks hand-computed values.
module tb_pipeline_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0, branch_taken = 1'b0, mem_busy = 1'b0;

  logic        pc3, ifid3, flush3, bub3;
  logic [3:0]  cnt3;
  logic [1:0]  st3;
  logic        pc1, ifid1, flush1, bub1;
  logic [15:0] cnt1;
  logic [1:0]  st1;
  logic [3:0]  ctl3, ctl1;

  int errors = 0;
  int checks = 0;

  assign ctl3 = {pc3, ifid3, flush3, bub3};
  assign ctl1 = {pc1, ifid1, flush1, bub1};

  always #5 Clk = ~Clk;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(3), .CNT_W(4)) dut3 (
    .Clk(Clk), .Reset(Reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .pc_write_en(pc3), .if_id_write_en(ifid3),
    .if_id_flush(flush3), .id_ex_bubble(bub3), .stall_count(cnt3), .ctrl_state(st3)
  );

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(1), .CNT_W(16)) dut1 (
    .Clk(Clk), .Reset(Reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .pc_write_en(pc1), .if_id_write_en(ifid1),
    .if_id_flush(flush1), .id_ex_bubble(bub1), .stall_count(cnt1), .ctrl_state(st1)
  );

  // Drive one cycle's inputs at the falling edge, then settle before checking.
  task automatic cyc(input logic rst, input logic mb, input logic br, input logic rd_en,
                     input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urt);
    @(negedge Clk);
    Reset = rst; mem_busy = mb; branch_taken = br; ex_mem_read = rd_en;
    ex_rd = rd; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    #2;
    $display("t=%0t rst=%b mb=%b br=%b lu_in=%b/%0d/%0d/%0d/%b | ctl=%b st=%0d cnt=%0d | ctl1=%b st1=%0d cnt1=%0d",
             $time, rst, mb, br, rd_en, rd, rs, rt, urt, ctl3, st3, cnt3, ctl1, st1, cnt1);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic test_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    checks++;
    if (ctl3 !== 4'b0000) begin errors++; $display("FAIL reset_forced_outputs: got %b want 0000", ctl3); end
    idle();
    checks++;
    if (ctl3 !== 4'b1100) begin errors++; $display("FAIL reset_release_ctl: got %b want 1100", ctl3); end
    checks++;
    if (cnt3 !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", cnt3); end
    checks++;
    if (st3 !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", st3); end
    checks++;
    if (cnt1 !== 16'd0) begin errors++; $display("FAIL reset_count_dut1: got %0d want 0", cnt1); end
  endtask

  task automatic test_load_use();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
    checks++;
    if (ctl3 !== 4'b0001) begin errors++; $display("FAIL lu_rs_stall: got %b want 0001", ctl3); end
    // Same operands still present: must not stall a second time.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
    checks++;
    if (st3 !== 2'd1) begin errors++; $display("FAIL lu_state: got %0d want 1", st3); end
    checks++;
    if (ctl3 !== 4'b1100) begin errors++; $display("FAIL lu_no_double: got %b want 1100", ctl3); end
    checks++;
    if (cnt3 !== 4'd1) begin errors++; $display("FAIL lu_count: got %0d want 1", cnt3); end
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    checks++;
    if (st3 !== 2'd0) begin errors++; $display("FAIL lu_back_to_run: got %0d want 0", st3); end
    checks++;
    if (ctl3 !== 4'b1100) begin errors++; $display("FAIL lu_zero_reg: got %b want 1100", ctl3); end
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd3, 5'd5, 1'b0);
    checks++;
    if (ctl3 !== 4'b1100) begin errors++; $display("FAIL lu_rt_unused: got %b want 1100", ctl3); end
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd3, 5'd5, 1'b1);
    checks++;
    if (ctl3 !== 4'b0001) begin errors++; $display("FAIL lu_rt_stall: got %b want 0001", ctl3); end
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 5'd6, 5'd3, 5'd4, 1'b1);
    checks++;
    if (ctl3 !== 4'b1100) begin errors++; $display("FAIL lu_no_match: got %b want 1100", ctl3); end
    checks++;
    if (cnt3 !== 4'd2) begin errors++; $display("FAIL lu_count2: got %0d want 2", cnt3); end
    idle();
  endtask

  task automatic test_branch();
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    checks++;
    if (ctl3 !== 4'b1111) begin errors++; $display("FAIL br_cycle1: got %b want 1111", ctl3); end
    checks++;
    if (ctl1 !== 4'b1111) begin errors++; $display("FAIL br_cycle1_dut1: got %b want 1111", ctl1); end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    checks++;
    if (st3 !== 2'd2 || ctl3 !== 4'b1111) begin errors++; $display("FAIL br_cycle2: got st=%0d ctl=%b want st=2 ctl=1111", st3, ctl3); end
    checks++;
    if (st1 !== 2'd0 || ctl1 !== 4'b1100) begin errors++; $display("FAIL br_single_dut1: got st=%0d ctl=%b want st=0 ctl=1100", st1, ctl1); end
    // Wrong-path branch and load-use in FLUSH are ignored.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0);
    checks++;
    if (st3 !== 2'd2 || ctl3 !== 4'b1111) begin errors++; $display("FAIL br_cycle3: got st=%0d ctl=%b want st=2 ctl=1111", st3, ctl3); end
    idle();
    checks++;
    if (st3 !== 2'd0 || ctl3 !== 4'b1100) begin errors++; $display("FAIL br_done: got st=%0d ctl=%b want st=0 ctl=1100", st3, ctl3); end
    checks++;
    if (cnt3 !== 4'd2) begin errors++; $display("FAIL br_count: got %0d want 2", cnt3); end
  endtask

  task automatic test_mem_wait();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      checks++;
      if (ctl3 !== 4'b0000) begin errors++; $display("FAIL mw_freeze[%0d]: got %b want 0000", i, ctl3); end
      checks++;
      if (st3 !== ((i == 0) ? 2'd0 : 2'd3)) begin errors++; $display("FAIL mw_state[%0d]: got %0d", i, st3); end
    end
    idle();
    checks++;
    if (ctl3 !== 4'b1100 || st3 !== 2'd3) begin errors++; $display("FAIL mw_release: got ctl=%b st=%0d want ctl=1100 st=3", ctl3, st3); end
    checks++;
    if (cnt3 !== 4'd4) begin errors++; $display("FAIL mw_count: got %0d want 4", cnt3); end
    idle();
    checks++;
    if (st3 !== 2'd0) begin errors++; $display("FAIL mw_back_to_run: got %0d want 0", st3); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
      checks++;
      if (ctl3 !== 4'b0000) begin errors++; $display("FAIL sim_freeze[%0d]: got %b want 0000", i, ctl3); end
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
    checks++;
    if (ctl3 !== 4'b1111) begin errors++; $display("FAIL sim_branch_first: got %b want 1111", ctl3); end
    idle();
    checks++;
    if (st3 !== 2'd2 || ctl3 !== 4'b1111) begin errors++; $display("FAIL sim_flush2: got st=%0d ctl=%b", st3, ctl3); end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      checks++;
      if (st3 !== 2'd2 || ctl3 !== 4'b0000) begin errors++; $display("FAIL sim_flush_freeze[%0d]: got st=%0d ctl=%b want st=2 ctl=0000", i, st3, ctl3); end
    end
    idle();
    checks++;
    if (st3 !== 2'd2 || ctl3 !== 4'b1111) begin errors++; $display("FAIL sim_flush_resume: got st=%0d ctl=%b want st=2 ctl=1111", st3, ctl3); end
    idle();
    checks++;
    if (st3 !== 2'd0 || ctl3 !== 4'b1100) begin errors++; $display("FAIL sim_done: got st=%0d ctl=%b want st=0 ctl=1100", st3, ctl3); end
    checks++;
    if (cnt3 !== 4'd8) begin errors++; $display("FAIL sim_count: got %0d want 8", cnt3); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      if (i == 7) begin
        checks++;
        if (cnt3 !== 4'd15) begin errors++; $display("FAIL sat_reach: got %0d want 15", cnt3); end
      end
    end
    idle();
    checks++;
    if (cnt3 !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d want 15", cnt3); end
    checks++;
    if (cnt1 !== 16'd28) begin errors++; $display("FAIL sat_wide_count: got %0d want 28", cnt1); end
  endtask

  task automatic test_reset_mid_flush();
    idle();
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    checks++;
    if (st3 !== 2'd2 || ctl3 !== 4'b0000) begin errors++; $display("FAIL rmf_forced: got st=%0d ctl=%b want st=2 ctl=0000", st3, ctl3); end
    idle();
    checks++;
    if (st3 !== 2'd0 || cnt3 !== 4'd0 || ctl3 !== 4'b1100) begin errors++; $display("FAIL rmf_cleared: got st=%0d cnt=%0d ctl=%b want st=0 cnt=0 ctl=1100", st3, cnt3, ctl3); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_simultaneous();
    test_saturation();
    test_reset_mid_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequences the IF/ID pipeline registers and the PC register.
- Drives the PC write enable, the IF/ID register write enable, the IF/ID flush, and the ID/EX bubble insert.
- Handles three hazard cases:
  - load-use stalls (1 cycle),
  - taken-branch flushes (FLUSH_CYCLES penalty),
  - data-memory wait freezes (unbounded).
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- FLUSH_CYCLES, 1, wrong-path cycles squashed per taken branch. Legal range is 1..15.
- CNT_W, 16, stall counter width.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- id_rs  in  REG_ADDR_W  source register 1 of the instruction in ID.
- id_rt  in  REG_ADDR_W  source register 2 of the instruction in ID.
- id_uses_rt  in  1  the ID instruction reads id_rt.
- ex_mem_read  in  1  the EX instruction is a load.
- ex_rd  in  REG_ADDR_W  destination register of the EX instruction.
- branch_taken  in  1  a branch resolved taken in EX this cycle. Held stable while the pipe is frozen.
- mem_busy  in  1  data memory not ready; the whole pipe must freeze.
- pc_write_en  out  1  PC register write enable.
- if_id_write_en  out  1  write enable for all IF/ID registers.
- if_id_flush  out  1  IF/ID registers load the NOP/zero value.
- id_ex_bubble  out  1  ID/EX control fields are zeroed.
- stall_count  out  CNT_W  saturating count of cycles with pc_write_en=0.
- ctrl_state  out  2  current FSM state, for debug.

Behaviour:
- The FSM state, flush counter fcnt (4 bit) and stall_count are registered. The four control outputs are combinational from state, fcnt and inputs (zero-latency decision).
- States: RUN=0, LU_STALL=1, FLUSH=2, MEM_WAIT=3.
- Reset low at a clock edge gives state=RUN, fcnt=0, stall_count=0.
  - While Reset is low, the outputs are forced: pc_write_en=0, if_id_write_en=0, if_id_flush=0, id_ex_bubble=0.
- Load-use hazard lu, all must hold:
  - ex_mem_read=1,
  - ex_rd!=0,
  - ex_rd==id_rs, or (id_uses_rt=1 and ex_rd==id_rt).
- Default outputs: we/pc=1, flush=0, bubble=0.
- Priority within a cycle is mem_busy > branch_taken > lu.
- RUN:
  - mem_busy: pc_we=0, if_id_we=0, flush=0, bubble=0; next MEM_WAIT.
  - else branch_taken: pc_we=1 (target load), if_id_flush=1, id_ex_bubble=1. Next is RUN if FLUSH_CYCLES==1; otherwise next is FLUSH with fcnt=FLUSH_CYCLES-1.
  - else lu: pc_we=0, if_id_we=0, id_ex_bubble=1; next LU_STALL.
  - else: defaults; stay in RUN.
- LU_STALL:
  - mem_busy: freeze as in RUN; next MEM_WAIT.
  - otherwise identical to RUN, except lu is ignored for this one cycle (no back-to-back stall on the same load).
- FLUSH:
  - mem_busy: full freeze; fcnt holds; stay in FLUSH.
  - else: pc_we=1, if_id_we=1, if_id_flush=1, id_ex_bubble=1, fcnt-=1. Next RUN when fcnt==1, else stay in FLUSH.
  - branch_taken and lu are ignored in FLUSH (wrong-path bubbles).
- MEM_WAIT:
  - mem_busy=1: full freeze (all four outputs 0).
  - mem_busy=0: outputs and next state are evaluated exactly as RUN in the same cycle, so there is no extra dead cycle.
- stall_count increments on every non-reset cycle with pc_write_en=0 and saturates at all-ones. There is no wrap.
- if_id_flush=1 always implies if_id_write_en=1. pc_write_en=0 always implies if_id_write_en=0.

Decomposition:
- Shared package ctrl_pkg holds:
  - state enum (RUN/LU_STALL/FLUSH/MEM_WAIT, 2-bit encoding above),
  - REG_ADDR_W default,
  - the zero-register constant.
- One sub-module, load_use_detect: purely combinational, takes ex_mem_read/ex_rd/id_rs/id_rt/id_uses_rt and outputs lu.
- The FSM, flush counter and stall counter stay in the top module.

Test Plan:
1. Reset=0 for 2 cycles, then 1, with all inputs 0 -> outputs pc_we=1, if_id_we=1, flush=0, bubble=0; stall_count=0; ctrl_state=0.
2. Load-use: ex_mem_read=1, ex_rd=5, id_rs=5 for one cycle -> that cycle pc_we=0, if_id_we=0, bubble=1; next cycle ctrl_state=1 with defaults; stall_count=1.
   - Repeat with ex_rd=0, or with id_rt=5 and id_uses_rt=0 -> no stall.
3. Taken branch with FLUSH_CYCLES=3 -> three consecutive cycles of flush=1, bubble=1, pc_we=1; ctrl_state=2 for cycles 2-3, then 0.
4. mem_busy high for 4 cycles starting in RUN -> 4 cycles with all outputs 0; ctrl_state=3 after the first cycle; stall_count=4. On the cycle mem_busy drops, outputs return to defaults.
5. Simultaneous events:
   - mem_busy=1, branch_taken=1 and lu=1 together -> freeze only; after mem_busy drops, the branch flush is applied first.
   - mem_busy asserted mid-FLUSH -> fcnt is held and flush resumes afterwards.
6. Saturation with CNT_W=4: hold mem_busy for 20 cycles -> stall_count=15 and stays 15.
   - Reset low mid-FLUSH -> next cycle ctrl_state=0 and stall_count=0.
